// File: rtl/pbcd_to_binary.sv
// ---------------------------------------------------------------------------
// pbcd_to_binary
//
// Sequential pseudo-BCD to binary converter (reverse double-dabble). This is
// the inverse of the binary -> pseudo-BCD path that feeds the display. It loads
// keypad or decimal entry back into the binary accumulator.
//
// Each decimal digit arrives in a 5-bit field: a 4-bit BCD digit plus one pad
// bit above it, which must be zero. A valid request shifts the digit register
// into a binary register one bit per clock, for OUT_W clocks. Any digit field
// that is not 0..9, or any pad bit that is set, makes the request fail. A failed
// request completes quickly with a result of 0 and err set.
//
// Ports
//   clk      in   1        system clock, rising edge
//   reset    in   1        synchronous, active-high reset
//   start    in   1        conversion request, sampled only while idle
//   pbcd     in   5*NDIG   digit d at [5d+3:5d], pad bit at [5d+4]
//   acc_out  out  OUT_W    converted value, held until the next completion
//   busy     out  1        high from the accepting edge until back in IDLE
//   done     out  1        one-cycle completion pulse
//   err      out  1        last completed request had a bad digit or pad bit
//
// Parameters
//   NDIG     number of decimal digits
//   OUT_W    binary width; 10**NDIG-1 must fit in OUT_W bits
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | valid: one right shift + digit correction per clock, OUT_W times
//       | invalid: a single reject cycle, no shifting
// DONE  | result registered, done pulse high; returns to IDLE next clock
// ---------------------------------------------------------------------------

module pbcd_to_binary #(
    parameter int NDIG  = 2,
    parameter int OUT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [5*NDIG-1:0]   pbcd,
    output logic [OUT_W-1:0]    acc_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DIG_W  = 4 * NDIG;
    localparam int WORK_W = DIG_W + OUT_W;
    localparam int CNT_W  = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [WORK_W-1:0]   work;
    logic [CNT_W-1:0]    shift_cnt;
    logic                bad_req;

    logic                pbcd_ok;
    logic [DIG_W-1:0]    pbcd_digits;
    logic [WORK_W-1:0]   work_next;

    // Strip the pad bits and check every field.
    always_comb begin
        pbcd_ok     = 1'b1;
        pbcd_digits = '0;
        for (int d = 0; d < NDIG; d++) begin
            pbcd_digits[4*d +: 4] = pbcd[5*d +: 4];
            if (pbcd[5*d+4] || (pbcd[5*d +: 4] > 4'd9))
                pbcd_ok = 1'b0;
        end
    end

    // One reverse double-dabble step. First shift the whole register right.
    // Then take 3 from every digit that is now 8 or more. A digit that is 8 or
    // more has its top bit set, so the subtraction cannot underflow.
    always_comb begin
        work_next = work >> 1;
        for (int d = 0; d < NDIG; d++) begin
            if (work_next[OUT_W + 4*d + 3])
                work_next[OUT_W + 4*d +: 4] = work_next[OUT_W + 4*d +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            shift_cnt <= '0;
            bad_req   <= 1'b0;
            acc_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        busy      <= 1'b1;
                        shift_cnt <= '0;
                        if (pbcd_ok) begin
                            work    <= {pbcd_digits, {OUT_W{1'b0}}};
                            bad_req <= 1'b0;
                        end else begin
                            work    <= '0;
                            bad_req <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (bad_req) begin
                        // A rejected request spends one cycle here.
                        // It shifts nothing, and then reports 0 with err set.
                        state   <= DONE;
                        acc_out <= '0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        work      <= work_next;
                        shift_cnt <= shift_cnt + CNT_W'(1);
                        if (shift_cnt == CNT_W'(OUT_W - 1)) begin
                            // Take the result from the final shift.
                            // It is not read back from work.
                            state   <= DONE;
                            acc_out <= work_next[OUT_W-1:0];
                            err     <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbcd_to_binary.sv
module tb_pbcd_to_binary;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] pbcd;
    logic [7:0] acc_out;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pbcd_to_binary #(.NDIG(2), .OUT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pbcd    (pbcd),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Behavioural model: decimal value by arithmetic, latency as a countdown.
    bit         chk_en = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_acc  = 8'h00;
    logic [7:0] m_res  = 8'h00;
    bit         m_bad  = 1'b0;
    int         m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_acc  = 8'h00;
            m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_acc  = m_res;
                m_err  = m_bad;
            end
        end else if (start) begin
            int ones, tens;
            ones   = int'(pbcd[3:0]);
            tens   = int'(pbcd[8:5]);
            m_busy = 1'b1;
            m_bad  = pbcd[4] || pbcd[9] || ones > 9 || tens > 9;
            m_res  = m_bad ? 8'h00 : 8'(tens * 10 + ones);
            m_left = m_bad ? 1 : 8;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(busy),    32'(m_busy));
            check("done",    32'(done),    32'(m_done));
            check("acc_out", 32'(acc_out), 32'(m_acc));
            check("err",     32'(err),     32'(m_err));
        end
    end

    function automatic logic [9:0] enc(input int v);
        return {1'b0, 4'(v / 10), 1'b0, 4'(v % 10)};
    endfunction

    task automatic send(input logic [9:0] v);
        @(negedge clk);
        pbcd  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of edges after the accepting edge until done is seen,
    // or 0 on timeout (which is counted as a failure).
    task automatic wait_done(input int max, output int lat);
        lat = 0;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                lat = i + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles at %0t", max, $time);
        end
    endtask

    task automatic wait_done_from_send(output int lat);
        // Called at the negedge after the accepting edge k.
        // Done is first visible at the negedge that follows edge k+lat.
        int l;
        @(negedge clk);
        wait_done(20, l);
        lat = l;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start = 1'b0;
        pbcd  = 10'd0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_acc",  32'(acc_out), 32'h00);
        check("rst_busy", 32'(busy),    32'h0);
        check("rst_done", 32'(done),    32'h0);
        check("rst_err",  32'(err),     32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 42
        send(10'b00100_00010);
        check("t1_busy", 32'(busy), 32'h1);
        wait_done_from_send(lat);
        check("t1_lat", 32'(lat), 32'd8);
        check("t1_acc", 32'(acc_out), 32'h2A);
        check("t1_err", 32'(err), 32'h0);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'h0);

        // 99 and 00
        send(10'b01001_01001);
        wait_done_from_send(lat);
        check("t2_acc99", 32'(acc_out), 32'h63);
        send(10'b00000_00000);
        wait_done_from_send(lat);
        check("t2_acc00", 32'(acc_out), 32'h00);
        check("t2_err", 32'(err), 32'h0);

        // bad digit, then set pad bit
        send(10'b00000_01010);
        wait_done_from_send(lat);
        check("t3_lat", 32'(lat), 32'd1);
        check("t3_acc", 32'(acc_out), 32'h00);
        check("t3_err", 32'(err), 32'h1);
        send(10'b00000_10000);
        wait_done_from_send(lat);
        check("t3_pad_lat", 32'(lat), 32'd1);
        check("t3_pad_err", 32'(err), 32'h1);

        // start while busy is ignored
        send(enc(42));
        @(negedge clk);
        pbcd  = enc(17);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, lat);
        check("t4_acc42", 32'(acc_out), 32'h2A);
        check("t4_err", 32'(err), 32'h0);
        send(enc(17));
        wait_done_from_send(lat);
        check("t4_acc17", 32'(acc_out), 32'h11);

        // reset after 4 shifts
        send(enc(42));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_acc",  32'(acc_out), 32'h00);
        reset = 1'b0;
        send(enc(7));
        wait_done_from_send(lat);
        check("t5_lat", 32'(lat), 32'd8);
        check("t5_acc7", 32'(acc_out), 32'h07);

        // all 0..99 back to back, start held high
        @(negedge clk);
        pbcd  = enc(0);
        start = 1'b1;
        for (int v = 0; v < 100; v++) begin
            @(negedge clk);
            wait_done(20, lat);
            check("t6_acc", 32'(acc_out), 32'(v));
            check("t6_err", 32'(err), 32'h0);
            pbcd = enc((v + 1) % 100);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
